// File: rtl/matrix_ascii_tx.sv
// Prints a signed matrix from synchronous storage as ASCII decimal text, row-major, space/LF separated.
// One read per element, up to 10 divide-by-ten steps, then one byte per cycle while tx_ready holds.
module matrix_ascii_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] storage_rd_addr,
  input  logic [DATA_WIDTH-1:0] storage_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, CONV, SEND_SIGN, SEND_DIGIT, SEND_SEP, FINISH
  } state_t;

  localparam logic [DATA_WIDTH-1:0] TEN = DATA_WIDTH'(10);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [7:0]              rows_q, cols_q, row_cnt, col_cnt;
  logic                    neg;
  logic [DATA_WIDTH-1:0]   mag, mag_div, mag_mod;
  logic [3:0]              digs [0:9];
  logic [3:0]              ndig, dig_idx;
  logic                    last_col, last_row;

  assign storage_rd_addr = rd_addr;
  assign mag_div  = mag / TEN;
  assign mag_mod  = mag % TEN;
  assign last_col = (col_cnt == cols_q - 8'd1);
  assign last_row = (row_cnt == rows_q - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      IDLE:      if (start && rows != 8'd0 && cols != 8'd0) state_nx = READ;
      READ:      state_nx = WAIT;
      WAIT:      state_nx = CONV;
      CONV:      if (mag_div == '0) state_nx = neg ? SEND_SIGN : SEND_DIGIT;
      SEND_SIGN: begin
        tx_valid = 1'b1;
        tx_data  = 8'h2D;
        if (tx_ready) state_nx = SEND_DIGIT;
      end
      SEND_DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = {4'h3, digs[dig_idx]};
        if (tx_ready && dig_idx == 4'd0) state_nx = SEND_SEP;
      end
      SEND_SEP: begin
        tx_valid = 1'b1;
        tx_data  = last_col ? 8'h0A : 8'h20;
        if (tx_ready) state_nx = (last_col && last_row) ? FINISH : READ;
      end
      FINISH:    begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      neg     <= 1'b0;
      mag     <= '0;
      ndig    <= '0;
      dig_idx <= '0;
      error   <= 1'b0;
      for (int i = 0; i < 10; i++) digs[i] <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (rows != 8'd0 && cols != 8'd0) begin
            rows_q  <= rows;
            cols_q  <= cols;
            row_cnt <= '0;
            col_cnt <= '0;
            rd_addr <= base_addr;
          end else begin
            error <= 1'b1;
          end
        end
        WAIT: begin
          // Two's-complement negate into an unsigned magnitude so the most negative value fits.
          neg  <= storage_rd_data[DATA_WIDTH-1];
          mag  <= storage_rd_data[DATA_WIDTH-1] ? (~storage_rd_data + 1'b1) : storage_rd_data;
          ndig <= '0;
        end
        CONV: begin
          // Digits are produced least-significant first and replayed in reverse.
          digs[ndig] <= mag_mod[3:0];
          mag        <= mag_div;
          ndig       <= ndig + 4'd1;
          if (mag_div == '0) dig_idx <= ndig;
        end
        SEND_DIGIT: if (tx_ready && dig_idx != 4'd0) dig_idx <= dig_idx - 4'd1;
        SEND_SEP: if (tx_ready && !(last_col && last_row)) begin
          rd_addr <= rd_addr + 1'b1;
          if (last_col) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 8'd1;
          end else begin
            col_cnt <= col_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_ascii_tx.md
MATRIX_ASCII_TX -- requirements
Module: matrix_ascii_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning storage word width (signed two's-complement element).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning storage read address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to print one matrix.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  storage address of element (0,0), sampled on accepted start.
REQ-008 SHALL have port rows  input  8  row count, sampled on accepted start.
REQ-009 SHALL have port cols  input  8  column count, sampled on accepted start.
REQ-010 SHALL have port busy  output  1  print in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the print completes.
REQ-012 SHALL have port error  output  1  one-cycle pulse when a start is rejected.
REQ-013 SHALL have port storage_rd_addr  output  ADDR_WIDTH  storage read address.
REQ-014 SHALL have port storage_rd_data  input  DATA_WIDTH  storage read data, valid exactly 1 cycle after the address.
REQ-015 SHALL have port tx_data  output  8  ASCII byte toward the UART transmitter.
REQ-016 SHALL have port tx_valid  output  1  tx_data holds a byte.
REQ-017 SHALL have port tx_ready  input  1  UART transmitter accepts the byte.

Function
REQ-018 SHALL be in state IDLE when not printing; the states are IDLE, READ, WAIT, CONV, SEND_SIGN, SEND_DIGIT, SEND_SEP, FINISH.
REQ-019 SHALL accept start only in IDLE; start while busy SHALL be ignored with no effect on output or state.
REQ-020 SHALL, on an accepted start with rows==0 or cols==0, pulse error for one cycle, stay in IDLE, and emit no bytes.
REQ-021 SHALL otherwise latch base_addr, rows and cols, and assert busy from the next cycle until the done cycle inclusive.
REQ-022 SHALL visit elements in row-major order at address base_addr + r*cols + c, computed modulo 2^ADDR_WIDTH (wrap-around).
REQ-023 SHALL drive storage_rd_addr in READ and capture storage_rd_data in WAIT, one cycle later.
REQ-024 SHALL, in CONV, convert the captured word to unsigned magnitude and at most 10 decimal digits, taking no more than 40 cycles per element.
REQ-025 SHALL emit 0x2D ('-') first for negative values, then digits most-significant first, with no leading zeros; zero SHALL emit 0x30 only.
REQ-026 SHALL print -2^31 as "-2147483648", using a 32-bit unsigned magnitude.
REQ-027 SHALL emit 0x20 (space) after each element except the last of a row.
REQ-028 SHALL emit 0x0A after the last element of each row; there SHALL be no trailing space and no 0x0D.
REQ-029 SHALL complete a byte transfer on a rising edge where tx_valid && tx_ready.
REQ-030 SHALL hold tx_data stable and keep tx_valid high until that transfer completes.
REQ-031 SHALL be capable of sustaining one transfer per cycle within the digits of one element.
REQ-032 SHALL, after the final 0x0A transfers, enter FINISH, pulse done for one cycle, deassert busy on the next cycle, and return to IDLE.
REQ-033 SHALL hold storage_rd_addr at its last value outside READ/WAIT.

Reset
REQ-034 SHALL, when rst is asserted (any cycle, including mid-element or mid-handshake), immediately force state=IDLE, busy=0, done=0, error=0, tx_valid=0, tx_data=0x00, storage_rd_addr=0, and clear all counters.
REQ-035 SHALL respond normally to a new start on the first rising edge after rst deasserts.

Verification
REQ-036 2x3 at base 0x0100, data [1,-2,30; 0,2147483647,-2147483648], tx_ready=1 -> bytes "1 -2 30\n0 2147483647 -2147483648\n", reads 0x0100..0x0105 in order, one done pulse.
REQ-037 Same stimulus with tx_ready pseudo-random 30% high -> identical byte stream; tx_data unchanged every cycle that tx_valid && !tx_ready.
REQ-038 start with rows=0, cols=4 -> error high exactly one cycle, busy never high, tx_valid never high.
REQ-039 1x2 at base 0x3FFF, data [5,-7], plus a second start pulsed mid-print -> reads 0x3FFF then 0x0000, bytes "5 -7\n", second start ignored, one done pulse.
REQ-040 rst pulsed while tx_valid=1 during digit output -> all outputs at reset values; a new 1x1 [0] print -> "0\n" and done.
